// File: rtl/jesd_tx_pattern_gen.sv
// rtl/jesd_tx_pattern_gen.sv - JESD TX user-data test source: one ramp/PRBS15 frame per trigger edge
//
// Purpose: on each rising edge of the switch input, emit FRAME_LEN 32-bit words
// into the JESD TX core, paced by tx_tready; drive IDLE_WORD otherwise.
// Optional feature macro: JESD_TX_PRBS_EN (adds PRBS15 frames selected by mode=1).
//
// Ports:
//   sysclk       in   clock, all logic on its rising edge
//   reset        in   synchronous, active-high
//   trig_in      in   asynchronous switch level; each rising edge starts one frame
//   mode         in   0 = ramp, 1 = PRBS15 (only with JESD_TX_PRBS_EN)
//   tx_tready    in   TX core accepts tx_tdata on every cycle this is 1
//   tx_tdata     out  sample word, [15:0] even sample, [31:16] odd sample
//   busy         out  1 while a frame is being sent
//   frame_start  out  1-cycle pulse on the first cycle of a frame
//   frame_done   out  1-cycle pulse on the cycle after the last word is accepted
//   frame_cnt    out  completed frame count, wraps at 16 bits

module jesd_tx_pattern_gen #(
  parameter int unsigned FRAME_LEN = 256,
  parameter logic [15:0] START_VAL = 16'h0000,
  parameter logic [31:0] IDLE_WORD = 32'h0000_0000
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        trig_in,
  input  logic        mode,
  input  logic        tx_tready,
  output logic [31:0] tx_tdata,
  output logic        busy,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned   KW     = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [31:0]   tx_tdata_q, tx_tdata_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          s1_q, s2_q, s3_q;
  logic          rise;
  logic [KW-1:0] k_inc;

  // Ramp word k: even sample START_VAL+2k in the low half, odd sample above it.
  function automatic logic [31:0] ramp_word(input logic [15:0] k);
    logic [15:0] even;
    even = START_VAL + (k << 1);
    return {even + 16'd1, even};
  endfunction

`ifdef JESD_TX_PRBS_EN
  localparam logic [14:0] PRBS_SEED = 15'h7FFF;

  logic [14:0] lfsr_q, lfsr_d;
  logic        mode_q, mode_d;
  logic [46:0] prbs_nxt;

  // Advance x^15+x^14+1 by 32 steps. lfsr[0] holds the newest bit; each new
  // serial bit is also the output bit, so the first one lands in word[31].
  function automatic logic [46:0] prbs_step32(input logic [14:0] s);
    logic [14:0] st;
    logic [31:0] w;
    logic        b;
    st = s;
    w  = '0;
    for (int i = 0; i < 32; i++) begin
      b  = st[14] ^ st[13];
      st = {st[13:0], b};
      w  = {w[30:0], b};
    end
    return {w, st};
  endfunction
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  // Level-to-pulse: s3 is the delayed copy of the synchronised level.
  assign rise  = s2_q & ~s3_q;
  assign k_inc = k_q + KW'(1);

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    tx_tdata_d    = tx_tdata_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
`ifdef JESD_TX_PRBS_EN
    mode_d   = mode_q;
    lfsr_d   = lfsr_q;
    // Word 0 comes from the seed; later words continue from the held state.
    prbs_nxt = prbs_step32((state_q == SEND) ? lfsr_q : PRBS_SEED);
`endif
    case (state_q)
      IDLE: begin
        tx_tdata_d = IDLE_WORD;
        if (rise) begin
          state_d       = SEND;
          k_d           = '0;
          frame_start_d = 1'b1;
          tx_tdata_d    = ramp_word(16'd0);
`ifdef JESD_TX_PRBS_EN
          mode_d = mode;
          if (mode) begin
            tx_tdata_d = prbs_nxt[46:15];
            lfsr_d     = prbs_nxt[14:0];
          end
`endif
        end
      end
      SEND: begin
        // Without tready everything holds, so a stall of any length is lossless.
        if (tx_tready) begin
          if (k_q == K_LAST) begin
            state_d      = IDLE;
            tx_tdata_d   = IDLE_WORD;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end else begin
            k_d        = k_inc;
            tx_tdata_d = ramp_word(16'(k_inc));
`ifdef JESD_TX_PRBS_EN
            if (mode_q) begin
              tx_tdata_d = prbs_nxt[46:15];
              lfsr_d     = prbs_nxt[14:0];
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q       <= IDLE;
      k_q           <= '0;
      tx_tdata_q    <= IDLE_WORD;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= 16'd0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
`ifdef JESD_TX_PRBS_EN
      mode_q        <= 1'b0;
      lfsr_q        <= PRBS_SEED;
`endif
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      tx_tdata_q    <= tx_tdata_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      s1_q          <= trig_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
`ifdef JESD_TX_PRBS_EN
      mode_q        <= mode_d;
      lfsr_q        <= lfsr_d;
`endif
    end
  end

  assign tx_tdata    = tx_tdata_q;
  assign busy        = (state_q == SEND);
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
